pc_loop_monitor: RTL and testbench

//  Parametrised run-control monitor for the 5-stage pipeline. It watches the fetch PC stream
//  (sampled when the PC latch is enabled) and holds a DEPTH-entry PC history. It flags three

---
 rtl/pc_loop_monitor_pkg.sv | 17 +
 rtl/pc_history_cam.sv | 53 +++++
 rtl/pc_loop_monitor.sv | 133 +++++++++++++
 tb/tb_pc_loop_monitor.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_loop_monitor_pkg.sv
// Shared definitions for the PC run-control monitor.
//   state_t   : monitor state, also driven directly onto the status port
//   cnt_width : bits needed to hold a count from 0 up to and including limit
package pc_loop_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_LOOP = 2'b01,
    ST_DEAD = 2'b10,
    ST_TMO  = 2'b11
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/pc_history_cam.sv
// PC history: DEPTH-entry push-shift register with per-entry valid bits and a
// parallel compare of the incoming PC against every valid entry.
// Ports:
//   clk   in  1     rising-edge clock
//   clr   in  1     synchronous clear of all valid bits
//   push  in  1     shift history and write pc into entry 0
//   pc    in  PC_W  PC to compare / push
//   hit   out 1     pc matches a valid entry (combinational, pre-push contents)
module pc_history_cam
  import pc_loop_monitor_pkg::*;
#(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            push,
  input  logic [PC_W-1:0] pc,
  output logic            hit
);

  logic [PC_W-1:0]  entry [DEPTH];
  logic [DEPTH-1:0] valid;

  // Valid bits are the only state that needs clearing; stale data behind a
  // cleared valid bit can never produce a hit.
  always_ff @(posedge clk) begin
    if (clr) begin
      valid <= '0;
    end else if (push) begin
      valid <= {valid[DEPTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entry[0] <= pc;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        entry[i] <= entry[i-1];
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entry[i] == pc)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_loop_monitor.sv
// Run-control monitor for the 5-stage pipeline. Watches the fetch PC stream
// and halts on a halt loop (HIT_THRESH consecutive history hits), a deadlock
// (STALL_LIMIT consecutive cycles without pc_valid) or a timeout (MAX_CYCLES
// RUN cycles). Terminal states are sticky until reset or clear.
// Ports:
//   clk          in  1      rising-edge clock
//   reset        in  1      synchronous active-high reset
//   pc           in  PC_W   current fetch PC
//   pc_valid     in  1      PC advanced this cycle
//   clear        in  1      synchronous soft restart, identical to reset
//   halt         out 1      high in any terminal state
//   status       out 2      00 RUN, 01 LOOP, 10 DEADLOCK, 11 TIMEOUT
//   loop_pc      out PC_W   PC that completed the loop threshold
//   cycle_count  out CNT_W  RUN cycles elapsed
//   retire_count out CNT_W  pc_valid cycles seen in RUN
module pc_loop_monitor
  import pc_loop_monitor_pkg::*;
#(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HIT_THRESH  = 16,
  parameter int unsigned STALL_LIMIT = 64,
  parameter int unsigned MAX_CYCLES  = 4096,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
  input  logic             clear,
  output logic             halt,
  output logic [1:0]       status,
  output logic [PC_W-1:0]  loop_pc,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count
);

  localparam int unsigned HC_W = cnt_width(HIT_THRESH);
  localparam int unsigned SC_W = cnt_width(STALL_LIMIT);

  state_t          state_q, state_d;
  logic [HC_W-1:0] hit_cnt;
  logic [SC_W-1:0] stall_cnt;

  logic            restart;
  logic            run;
  logic            push;
  logic            hit;
  logic [HC_W:0]   hit_inc;
  logic [SC_W:0]   stall_inc;
  logic [CNT_W-1:0] cycle_inc;
  logic            loop_cond;
  logic            dead_cond;
  logic            tmo_cond;

  assign restart = reset | clear;
  assign run     = (state_q == ST_RUN);
  assign push    = run & pc_valid;

  pc_history_cam #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH)
  ) u_cam (
    .clk  (clk),
    .clr  (restart),
    .push (push),
    .pc   (pc),
    .hit  (hit)
  );

  // Increments carry one extra bit so the threshold compare is exact even
  // when the counter sits at its saturation value.
  assign hit_inc   = {1'b0, hit_cnt} + (HC_W+1)'(1);
  assign stall_inc = {1'b0, stall_cnt} + (SC_W+1)'(1);
  assign cycle_inc = cycle_count + CNT_W'(1);

  assign loop_cond = pc_valid & hit & (hit_inc == (HC_W+1)'(HIT_THRESH));
  assign dead_cond = ~pc_valid & (stall_inc == (SC_W+1)'(STALL_LIMIT));
  assign tmo_cond  = (cycle_inc == CNT_W'(MAX_CYCLES));

  always_ff @(posedge clk) begin
    if (restart) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (loop_cond) begin
        state_d = ST_LOOP;
      end else if (dead_cond) begin
        state_d = ST_DEAD;
      end else if (tmo_cond) begin
        state_d = ST_TMO;
      end
    end
  end

  // Counters keep updating in the cycle that leaves RUN; they freeze from the
  // first terminal cycle onward.
  always_ff @(posedge clk) begin
    if (restart) begin
      hit_cnt      <= '0;
      stall_cnt    <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
      loop_pc      <= '0;
    end else if (run) begin
      cycle_count <= cycle_inc;
      if (pc_valid) begin
        stall_cnt    <= '0;
        retire_count <= retire_count + CNT_W'(1);
        if (!hit) begin
          hit_cnt <= '0;
        end else if (!(&hit_cnt)) begin
          hit_cnt <= hit_inc[HC_W-1:0];
        end
      end else if (!(&stall_cnt)) begin
        stall_cnt <= stall_inc[SC_W-1:0];
      end
      if (loop_cond) begin
        loop_pc <= pc;
      end
    end
  end

  assign status = state_q;
  assign halt   = (state_q != ST_RUN);

endmodule

// File: tb/tb_pc_loop_monitor.sv
module tb_pc_loop_monitor;

  localparam int unsigned DEPTH       = 16;
  localparam int unsigned HIT_THRESH  = 16;
  localparam int unsigned STALL_LIMIT = 64;
  localparam int unsigned HC_MAX      = (1 << $clog2(HIT_THRESH + 1)) - 1;
  localparam int unsigned SC_MAX      = (1 << $clog2(STALL_LIMIT + 1)) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [31:0] pc = '0;
  logic        pc_valid = 1'b0;

  logic        halt_a, halt_b;
  logic [1:0]  status_a, status_b;
  logic [31:0] loop_pc_a, loop_pc_b, cyc_a, cyc_b, ret_a, ret_b;

  always #5 clk = ~clk;

  pc_loop_monitor #(
    .PC_W(32), .DEPTH(DEPTH), .HIT_THRESH(HIT_THRESH), .STALL_LIMIT(STALL_LIMIT),
    .MAX_CYCLES(4096), .CNT_W(32)
  ) dut_a (
    .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .clear(clear),
    .halt(halt_a), .status(status_a), .loop_pc(loop_pc_a),
    .cycle_count(cyc_a), .retire_count(ret_a)
  );

  pc_loop_monitor #(
    .PC_W(32), .DEPTH(DEPTH), .HIT_THRESH(HIT_THRESH), .STALL_LIMIT(STALL_LIMIT),
    .MAX_CYCLES(32), .CNT_W(32)
  ) dut_b (
    .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .clear(clear),
    .halt(halt_b), .status(status_b), .loop_pc(loop_pc_b),
    .cycle_count(cyc_b), .retire_count(ret_b)
  );

  // Observed outputs of the instance under test.
  bit          sel = 1'b0;
  logic        o_halt;
  logic [1:0]  o_status;
  logic [31:0] o_loop_pc, o_cyc, o_ret;
  logic [98:0] obs;

  always_comb begin
    o_halt    = sel ? halt_b    : halt_a;
    o_status  = sel ? status_b  : status_a;
    o_loop_pc = sel ? loop_pc_b : loop_pc_a;
    o_cyc     = sel ? cyc_b     : cyc_a;
    o_ret     = sel ? ret_b     : ret_a;
    obs       = {o_halt, o_status, o_cyc, o_ret, o_loop_pc};
  end

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: history as a queue (newest first) plus plain counters.
  int unsigned hist[$];
  int unsigned m_state, m_hit, m_stall, m_cyc, m_ret, m_loop;
  int unsigned m_max = 4096;

  function automatic logic [98:0] exp_vec();
    return {1'(m_state != 0), 2'(m_state), 32'(m_cyc), 32'(m_ret), 32'(m_loop)};
  endfunction

  task automatic model_reset();
    hist.delete();
    m_state = 0; m_hit = 0; m_stall = 0; m_cyc = 0; m_ret = 0; m_loop = 0;
  endtask

  task automatic model_step(input int unsigned p, input bit v);
    bit h;
    int unsigned ns;
    if (m_state != 0) return;
    h = 1'b0;
    foreach (hist[i]) if (hist[i] == p) h = 1'b1;
    ns = 0;
    if (v && h && (m_hit + 1 == HIT_THRESH)) ns = 1;
    else if (!v && (m_stall + 1 == STALL_LIMIT)) ns = 2;
    else if (m_cyc + 1 == m_max) ns = 3;
    if (ns == 1) m_loop = p;
    if (v) begin
      hist.push_front(p);
      if (hist.size() > DEPTH) void'(hist.pop_back());
      m_hit = h ? ((m_hit < HC_MAX) ? m_hit + 1 : m_hit) : 0;
      m_stall = 0;
      m_ret++;
    end else begin
      m_stall = (m_stall < SC_MAX) ? m_stall + 1 : m_stall;
    end
    m_cyc++;
    m_state = ns;
  endtask

  task automatic step(input int unsigned p, input bit v);
    pc = p;
    pc_valid = v;
    @(posedge clk);
    #1;
    model_step(p, v);
  endtask

  task automatic restart(input bit use_clear, input int unsigned n);
    if (use_clear) clear = 1'b1; else reset = 1'b1;
    pc = $urandom;
    pc_valid = 1'($urandom);
    repeat (n) @(posedge clk);
    #1;
    clear = 1'b0;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    restart(1'b0, 3);
    vectors++;
    if (obs !== '0 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_state: got %h required %h", obs, 99'd0);
    end
  endtask

  task automatic test_sequential();
    for (int unsigned i = 0; i < 16; i++) step(i * 4, 1'b1);
    vectors++;
    if (o_status !== 2'b00 || o_halt !== 1'b0 || o_ret !== 32'd16 || o_cyc !== 32'd16
        || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL seq16: got status=%0d halt=%0d cyc=%0d ret=%0d required 0 0 16 16",
               o_status, o_halt, o_cyc, o_ret);
    end
  endtask

  task automatic test_loop_self();
    restart(1'b0, 1);
    for (int unsigned i = 0; i < 16; i++) step(32'h20, 1'b1);
    vectors++;
    if (o_status !== 2'b00 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL self_pre: got %h required %h", obs, exp_vec());
    end
    step(32'h20, 1'b1);
    vectors++;
    if (o_status !== 2'b01 || o_halt !== 1'b1 || o_loop_pc !== 32'h20 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL self_loop: got status=%0d loop_pc=%h required 1 00000020", o_status, o_loop_pc);
    end
    for (int unsigned i = 0; i < 4; i++) step($urandom, 1'($urandom));
    vectors++;
    if (o_cyc !== 32'd17 || o_ret !== 32'd17 || o_status !== 2'b01 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL self_frozen: got cyc=%0d ret=%0d status=%0d required 17 17 1", o_cyc, o_ret, o_status);
    end
  endtask

  task automatic test_loop_body();
    int unsigned body [3] = '{32'h10, 32'h14, 32'h18};
    restart(1'b1, 1);
    for (int unsigned i = 0; i < 18; i++) step(body[i % 3], 1'b1);
    vectors++;
    if (o_status !== 2'b00 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL body_pre: got %h required %h", obs, exp_vec());
    end
    step(body[0], 1'b1);
    vectors++;
    if (o_status !== 2'b01 || o_loop_pc !== 32'h10 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL body_loop: got status=%0d loop_pc=%h required 1 00000010", o_status, o_loop_pc);
    end
  endtask

  task automatic test_deadlock();
    restart(1'b0, 1);
    for (int unsigned i = 0; i < 5; i++) step(32'h200 + i * 4, 1'b1);
    for (int unsigned i = 0; i < 63; i++) step($urandom, 1'b0);
    vectors++;
    if (o_status !== 2'b00 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL dead_63: got status=%0d required 0", o_status);
    end
    step($urandom, 1'b0);
    vectors++;
    if (o_status !== 2'b10 || o_halt !== 1'b1 || o_cyc !== 32'd69 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL dead_64: got status=%0d cyc=%0d required 2 69", o_status, o_cyc);
    end
    restart(1'b0, 1);
    for (int unsigned i = 0; i < 5; i++) step(32'h200 + i * 4, 1'b1);
    for (int unsigned i = 0; i < 63; i++) step($urandom, 1'b0);
    step(32'h300, 1'b1);
    for (int unsigned i = 0; i < 63; i++) step($urandom, 1'b0);
    vectors++;
    if (o_status !== 2'b00 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL dead_rearm: got status=%0d required 0", o_status);
    end
    step($urandom, 1'b0);
    vectors++;
    if (o_status !== 2'b10 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL dead_rearm64: got status=%0d required 2", o_status);
    end
  endtask

  task automatic test_timeout();
    sel = 1'b1;
    m_max = 32;
    restart(1'b0, 1);
    for (int unsigned i = 0; i < 31; i++) step(32'h1000 + i * 4, 1'($urandom_range(0, 3) != 0));
    vectors++;
    if (o_status !== 2'b00 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL tmo_31: got status=%0d required 0", o_status);
    end
    step(32'h2000, 1'b1);
    vectors++;
    if (o_status !== 2'b11 || o_cyc !== 32'd32 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL tmo_32: got status=%0d cyc=%0d required 3 32", o_status, o_cyc);
    end
    restart(1'b1, 1);
    for (int unsigned i = 0; i < 15; i++) step(32'h1000 + i * 4, 1'b1);
    for (int unsigned i = 0; i < 17; i++) step(32'h20, 1'b1);
    vectors++;
    if (o_status !== 2'b01 || o_cyc !== 32'd32 || o_loop_pc !== 32'h20 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL tmo_vs_loop: got status=%0d cyc=%0d required 1 32", o_status, o_cyc);
    end
    sel = 1'b0;
    m_max = 4096;
  endtask

  task automatic test_clear();
    for (int unsigned k = 0; k < 2; k++) begin
      restart(1'b0, 1);
      for (int unsigned i = 0; i < 17; i++) step(32'h20, 1'b1);
      vectors++;
      if (o_status !== 2'b01 || obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL clr_enter_loop%0d: got status=%0d required 1", k, o_status);
      end
      restart(k == 0, 1);
      vectors++;
      if (obs !== '0 || obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL clr_zero%0d: got %h required 0", k, obs);
      end
      for (int unsigned i = 0; i < 16; i++) step(32'h20, 1'b1);
      vectors++;
      if (o_status !== 2'b00 || obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL clr_hist%0d: got status=%0d required 0", k, o_status);
      end
      step(32'h20, 1'b1);
      vectors++;
      if (o_status !== 2'b01 || obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL clr_reloop%0d: got status=%0d required 1", k, o_status);
      end
    end
  endtask

  task automatic test_random();
    int unsigned set [4] = '{32'h400, 32'h404, 32'h408, 32'h40C};
    int unsigned p;
    restart(1'b0, 1);
    for (int unsigned n = 0; n < 800; n++) begin
      if ((m_state != 0 && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0) begin
        restart(1'($urandom), 1);
      end else begin
        p = ($urandom_range(0, 31) != 0) ? set[$urandom_range(0, 3)] : $urandom;
        step(p, 1'($urandom_range(0, 9) != 0));
      end
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h required %h", n, obs, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_loop_self();
    test_loop_body();
    test_deadlock();
    test_timeout();
    test_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
